// File: rtl/sipo_pkg.sv
// sipo_pkg -- shared types and constants for the serial-in/parallel-out
// deframer.
//   WIDTH_DEFAULT : default number of payload bits per word
//   state_t       : deframer FSM states (IDLE, SHIFT, PAR)
// PAR is only entered when SIPO_PARITY_CHECK_EN is defined.
package sipo_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/sipo_deframer_if.sv
// sipo_deframer_if -- output-side bus of the deframer.
//   dout, dout_valid : assembled word and its valid flag
//   dout_ready       : consumer accepts dout when valid and ready are both high
//   overflow         : sticky flag, a completed word was dropped
//   clr_ovf          : synchronous clear of overflow
//   parity_err       : parity result of the word on dout
// master = producer (output register), slave = consumer.
interface sipo_deframer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overflow;
  logic             clr_ovf;
  logic             parity_err;

  modport master (
    output dout, dout_valid, overflow, parity_err,
    input  dout_ready, clr_ovf
  );

  modport slave (
    input  dout, dout_valid, overflow, parity_err,
    output dout_ready, clr_ovf
  );

endinterface

// File: rtl/sipo_out_reg.sv
// sipo_out_reg -- one-word output register with valid/ready handshake and
// sticky overflow detection.
//   clk, rst   : clock, asynchronous active-low reset
//   word_done  : a word completed in this cycle (single-cycle pulse)
//   word       : the completed word
//   word_perr  : parity result belonging to word
//   bus        : master side of sipo_deframer_if
// A completed word is loaded when the register is empty or is being consumed
// in the same cycle; otherwise it is dropped and overflow is set.
module sipo_out_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word,
  input  logic             word_perr,
  sipo_deframer_if.master  bus
);

  logic handshake;
  logic load;
  logic drop;

  assign handshake = bus.dout_valid && bus.dout_ready;
  assign load      = word_done && (!bus.dout_valid || bus.dout_ready);
  assign drop      = word_done && bus.dout_valid && !bus.dout_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      if (load) begin
        bus.dout       <= word;
        bus.dout_valid <= 1'b1;
        bus.parity_err <= word_perr;
      end else if (handshake) begin
        // parity_err is only meaningful alongside a valid word
        bus.dout_valid <= 1'b0;
        bus.parity_err <= 1'b0;
      end
      // a drop in the same cycle as clr_ovf wins
      if (drop) begin
        bus.overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        bus.overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_deframer.sv
// sipo_deframer -- serial-to-parallel deframer, MSB first.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   sin        : serial data, sampled when sin_valid is high
//   sin_valid  : qualifies sin
//   dout       : assembled WIDTH-bit word
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer accepts dout
//   overflow   : sticky, a completed word was dropped
//   clr_ovf    : synchronous clear of overflow
//   parity_err : parity result for the word on dout
// Build option SIPO_PARITY_CHECK_EN: when defined each word is followed by an
// even-parity bit (PAR state); when undefined parity_err is always 0.
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             last_bit;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             word_perr;

  assign shift_next = {shift_reg[WIDTH-2:0], sin};
  assign last_bit   = (state_reg == SHIFT) && (count_reg == CW'(WIDTH - 1));

`ifdef SIPO_PARITY_CHECK_EN
  // payload is complete in shift_reg; the bit arriving now is the parity bit
  assign word_done = sin_valid && (state_reg == PAR);
  assign word      = shift_reg;
  assign word_perr = ^{shift_reg, sin};
`else
  // the final payload bit goes straight to the output register
  logic unused_msb;
  assign unused_msb = shift_reg[WIDTH-1];
  assign word_done  = sin_valid && last_bit;
  assign word       = shift_next;
  assign word_perr  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      shift_reg <= '0;
    end else if (sin_valid) begin
      case (state_reg)
        IDLE: begin
          shift_reg <= shift_next;
          count_reg <= CW'(1);
          state_reg <= SHIFT;
        end
        SHIFT: begin
          shift_reg <= shift_next;
          if (last_bit) begin
            count_reg <= '0;
`ifdef SIPO_PARITY_CHECK_EN
            state_reg <= PAR;
`else
            state_reg <= IDLE;
`endif
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        PAR: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
        end
      endcase
    end
  end

  sipo_deframer_if #(.WIDTH(WIDTH)) bus ();

  assign bus.dout_ready = dout_ready;
  assign bus.clr_ovf    = clr_ovf;
  assign dout           = bus.dout;
  assign dout_valid     = bus.dout_valid;
  assign overflow       = bus.overflow;
  assign parity_err     = bus.parity_err;

  sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .word_done (word_done),
    .word      (word),
    .word_perr (word_perr),
    .bus       (bus)
  );

endmodule

// File: doc/sipo_deframer.md
SIPO_DEFRAMER -- requirements
Module: sipo_deframer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the number of payload bits per word; legal range is 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port sin, input, 1 bit: serial data from the upstream parallel-to-serial stage.
REQ-005 SHALL have port sin_valid, input, 1 bit: sin is sampled only on cycles where this is high.
REQ-006 SHALL have port dout, output, WIDTH bits: the assembled parallel word.
REQ-007 SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-008 SHALL have port dout_ready, input, 1 bit: the consumer accepts dout when dout_valid and dout_ready are both high.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag set when a completed word is dropped.
REQ-010 SHALL have port clr_ovf, input, 1 bit: synchronous clear of overflow.
REQ-011 SHALL have port parity_err, output, 1 bit: parity result qualified by dout_valid (see Configuration).

Function
REQ-012 SHALL shift bits MSB-first: the first valid bit of a word lands in dout[WIDTH-1].
REQ-013 SHALL run an FSM with states IDLE (bit count 0), SHIFT (count 1..WIDTH-1) and PAR (parity bit expected; reachable only with the macro).
- IDLE->SHIFT on a valid bit.
- SHIFT advances the count on each valid bit.
- On the WIDTH-th valid bit: ->PAR with the macro, ->IDLE without it.
- PAR->IDLE on the next valid bit.
REQ-014 SHALL hold state and count unchanged on cycles with sin_valid low, with no timeout.
REQ-015 SHALL assert dout_valid, with the new word on dout, the cycle after the final bit of a word is sampled (latency 1 cycle).
REQ-016 SHALL keep dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-017 SHALL deassert dout_valid the cycle after a handshake, unless a new word completes in that same cycle; in that case SHALL load the new word and keep dout_valid=1.
REQ-018 SHALL, when a word completes while dout_valid=1 and dout_ready=0:
- drop the new word;
- keep dout unchanged;
- set overflow the next cycle;
- continue assembling the next word.
REQ-019 SHALL give set priority over clr_ovf when both occur in the same cycle.
REQ-020 SHALL accept back-to-back words with no idle cycle between them.

Reset
REQ-021 SHALL, while rst=0, force state=IDLE, count=0, dout=0, dout_valid=0, overflow=0 and parity_err=0, independent of clk.
REQ-022 SHALL discard any partially assembled word when reset is asserted mid-word; the first valid bit after release is an MSB.

Configuration
REQ-023 SHALL use macro SIPO_PARITY_CHECK_EN.
- Defined: each word is followed by one even-parity bit; parity_err is registered with the word and is 1 when XOR(payload, parity bit)=1; the PAR state exists.
- Undefined: no parity bit is expected; PAR is absent; parity_err is tied to 0.

Structure
REQ-024 SHALL place the FSM state enum (IDLE, SHIFT, PAR) and the WIDTH default constant in shared package sipo_pkg.
REQ-025 SHALL place the output register and handshake/overflow logic in one sub-module, sipo_out_reg; the FSM and shift register stay in the top level.

Verification
REQ-026 SHALL check reset: rst=0 mid-word after 2 bits, release, send 1,0,1,1 -> dout=4'b1011, dout_valid=1 one cycle after the 4th bit.
REQ-027 SHALL check gaps: send 0,0,1,1 with sin_valid low for 3 cycles between bits -> dout=4'b0011, overflow=0.
REQ-028 SHALL check backpressure: hold dout_ready=0 and send 1010 then 1111 -> dout stays 4'b1010, overflow=1 the cycle after the second word completes; clr_ovf=1 -> overflow=0.
REQ-029 SHALL check the simultaneous case: dout_ready=1 on the exact cycle the second word (1101) completes -> dout=4'b1101, dout_valid stays 1, overflow=0.
REQ-030 SHALL check parity with the macro defined: send 1100 with parity 0 -> parity_err=0; send 1011 with parity 0 -> parity_err=1.
REQ-031 SHALL check streaming: 8 back-to-back words with continuous sin_valid and dout_ready=1 -> 8 handshakes, no drops.
